// File: rtl/perf_event_monitor_if.sv
// Bundled control, readout and trace signals of perf_event_monitor.
// master drives stimulus/consumes results; slave is the monitor side.
interface perf_event_monitor_if #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int TRC_W   = 36
);
    localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

    logic               start;
    logic               clr;
    logic               halt;
    logic [NUM_EVT-1:0] evt;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic [NUM_EVT-1:0] sat;
    logic [1:0]         mon_state;
    logic               trc_valid;
    logic [TRC_W-1:0]   trc_data;
    logic               trc_pop;
    logic [TRC_W-1:0]   trc_rd_data;
    logic               trc_empty;
    logic               trc_full;
    logic [15:0]        trc_drop;

    modport master (
        output start, clr, halt, evt, rd_sel, trc_valid, trc_data, trc_pop,
        input  rd_data, sat, mon_state, trc_rd_data, trc_empty, trc_full, trc_drop
    );

    modport slave (
        input  start, clr, halt, evt, rd_sel, trc_valid, trc_data, trc_pop,
        output rd_data, sat, mon_state, trc_rd_data, trc_empty, trc_full, trc_drop
    );
endinterface

// File: rtl/perf_event_monitor.sv
// Per-event saturating performance counters with an optional commit-trace FIFO.
// Define PERF_TRACE_EN to build the trace FIFO; otherwise trace outputs are tied idle.
//
// state     | meaning
// ST_IDLE   | armed-off, counters hold, waiting for start
// ST_RUN    | counting events, trace records captured
// ST_FROZEN | halt seen, counters frozen until clr
module perf_event_monitor #(
    parameter int NUM_EVT    = 6,
    parameter int CNT_W      = 32,
    parameter int TRC_W      = 36,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst,
    perf_event_monitor_if.slave bus
);
    localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = bus.start ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (bus.start) state_nxt = ST_RUN;
                ST_RUN:    if (bus.halt)  state_nxt = ST_FROZEN;
                ST_FROZEN: state_nxt = ST_FROZEN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // clr wins over everything, including the halt-cycle events and trace push
    logic counting;
    assign counting = (state == ST_RUN) && !bus.clr;

    logic [CNT_W-1:0]   cnt [NUM_EVT];
    logic [NUM_EVT-1:0] sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVT; i++) cnt[i] <= '0;
            sat <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NUM_EVT; i++) cnt[i] <= '0;
            sat <= '0;
        end else if (counting) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                if (bus.evt[i]) begin
                    if (&cnt[i]) sat[i] <= 1'b1;
                    else         cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (int'(bus.rd_sel) == i) rd_mux = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_mux;
    end

    assign bus.rd_data   = rd_data;
    assign bus.sat       = sat;
    assign bus.mon_state = state;

`ifdef PERF_TRACE_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [TRC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [15:0]      drop;
    logic             empty, full, push_req, push_ok, pop_ok, drop_evt;

    // extra MSB on each pointer distinguishes full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_req = bus.trc_valid && counting;
    assign pop_ok   = bus.trc_pop && !empty && !bus.clr;
    assign push_ok  = push_req && (!full || pop_ok);
    assign drop_evt = push_req && full && !pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= '0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (drop_evt && (drop != 16'hFFFF)) drop <= drop + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= bus.trc_data;
    end

    assign bus.trc_rd_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign bus.trc_empty   = empty;
    assign bus.trc_full    = full;
    assign bus.trc_drop    = drop;
`else
    logic unused_trc;
    assign unused_trc = ^{bus.trc_valid, bus.trc_data, bus.trc_pop};

    assign bus.trc_rd_data = '0;
    assign bus.trc_empty   = 1'b1;
    assign bus.trc_full    = 1'b0;
    assign bus.trc_drop    = '0;
`endif

    logic [SEL_W-1:0] unused_sel;
    assign unused_sel = bus.rd_sel;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed plus randomized bench for perf_event_monitor against a queue/array reference model.
// Trace expectations follow PERF_TRACE_EN the same way the design does.
module tb_perf_event_monitor;
    localparam int NUM_EVT = 6;
    localparam int CNT_W   = 8;
    localparam int TRC_W   = 36;
    localparam int DEPTH   = 8;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perf_event_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .TRC_W(TRC_W)) bus();

    perf_event_monitor #(
        .NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .TRC_W(TRC_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: state as 0/1/2, counts as plain integers, trace as a queue
    int               m_state;
    longint           m_cnt [NUM_EVT];
    bit [NUM_EVT-1:0] m_sat;
    longint           m_rd;
    logic [TRC_W-1:0] m_q[$];
    int               m_drop;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = 0;
        m_sat  = '0;
        m_rd   = 0;
        m_q.delete();
        m_drop = 0;
    endtask

    task automatic model_edge();
        bit was_run;
        m_rd = 0;
        if (int'(bus.rd_sel) < NUM_EVT) m_rd = m_cnt[int'(bus.rd_sel)];
        if (bus.clr) begin
            for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = 0;
            m_sat = '0;
            m_q.delete();
            m_drop = 0;
            m_state = bus.start ? 1 : 0;
        end else begin
            was_run = (m_state == 1);
            if (was_run) begin
                for (int i = 0; i < NUM_EVT; i++) begin
                    if (bus.evt[i]) begin
                        if (m_cnt[i] == CNT_MAX) m_sat[i] = 1'b1;
                        else m_cnt[i]++;
                    end
                end
            end
`ifdef PERF_TRACE_EN
            if (bus.trc_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (bus.trc_valid && was_run) begin
                if (m_q.size() < DEPTH) m_q.push_back(bus.trc_data);
                else if (m_drop < 65535) m_drop++;
            end
`endif
            if (m_state == 0 && bus.start) m_state = 1;
            else if (m_state == 1 && bus.halt) m_state = 2;
        end
    endtask

    task automatic check_all();
        check_val("rd_data",   64'(bus.rd_data),   64'(m_rd));
        check_val("sat",       64'(bus.sat),       64'(m_sat));
        check_val("mon_state", 64'(bus.mon_state), 64'(m_state));
`ifdef PERF_TRACE_EN
        check_val("trc_empty",   64'(bus.trc_empty),   64'(m_q.size() == 0));
        check_val("trc_full",    64'(bus.trc_full),    64'(m_q.size() == DEPTH));
        check_val("trc_rd_data", 64'(bus.trc_rd_data), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
        check_val("trc_drop",    64'(bus.trc_drop),    64'(m_drop));
`else
        check_val("trc_empty",   64'(bus.trc_empty),   64'd1);
        check_val("trc_full",    64'(bus.trc_full),    64'd0);
        check_val("trc_rd_data", 64'(bus.trc_rd_data), 64'd0);
        check_val("trc_drop",    64'(bus.trc_drop),    64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.clr = 0; bus.halt = 0; bus.evt = '0;
        bus.trc_valid = 0; bus.trc_data = '0; bus.trc_pop = 0;
    endtask

    // Read counter sel through the 1-cycle readout path and compare with a literal
    task automatic read_cnt(input string tag, input int sel, input longint exp);
        bus.rd_sel = 3'(sel);
        step();
        check_val(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.rd_sel = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        check_val("reset_state", 64'(bus.mon_state), 64'd0);
        rst = 1'b0;

        // 1: ten evt[0] strobes in RUN
        bus.start = 1; step(); bus.start = 0;
        bus.evt = 6'b000001;
        for (int i = 0; i < 10; i++) step();
        bus.evt = '0;
        read_cnt("t1_cnt0", 0, 10);
        for (int s = 1; s < 8; s++) read_cnt("t1_other", s, 0);
        check_val("t1_state", 64'(bus.mon_state), 64'd1);

        // 2: halt on the 5th counted cycle freezes at 5
        bus.clr = 1; bus.start = 1; step(); bus.clr = 0; bus.start = 0;
        bus.evt = 6'b000001;
        for (int i = 1; i <= 5; i++) begin
            bus.halt = (i == 5);
            step();
        end
        bus.halt = 0;
        for (int i = 0; i < 20; i++) step();
        bus.evt = '0;
        read_cnt("t2_frozen_cnt", 0, 5);
        check_val("t2_state", 64'(bus.mon_state), 64'd2);

        // 6a: clr&start while FROZEN with counts
        bus.clr = 1; bus.start = 1; bus.evt = '1; step();
        bus.clr = 0; bus.start = 0; bus.evt = '0;
        check_val("t6_state_run", 64'(bus.mon_state), 64'd1);
        for (int s = 0; s < NUM_EVT; s++) read_cnt("t6_zero", s, 0);

        // 3: saturation of counter 2
        bus.evt = 6'b000100;
        for (int i = 0; i < 260; i++) step();
        bus.evt = '0;
        read_cnt("t3_sat_cnt", 2, CNT_MAX);
        check_val("t3_sat_flag", 64'(bus.sat), 64'h4);
        bus.clr = 1; step(); bus.clr = 0;
        read_cnt("t3_clr_cnt", 2, 0);
        check_val("t3_clr_sat", 64'(bus.sat), 64'd0);
        check_val("t3_clr_state", 64'(bus.mon_state), 64'd0);

        // 4: overflow the trace FIFO, then drain in order
        bus.start = 1; step(); bus.start = 0;
        bus.trc_valid = 1;
        for (int i = 0; i < 10; i++) begin
            bus.trc_data = TRC_W'(i);
            step();
        end
        bus.trc_valid = 0;
`ifdef PERF_TRACE_EN
        check_val("t4_full", 64'(bus.trc_full), 64'd1);
        check_val("t4_drop", 64'(bus.trc_drop), 64'd2);
`endif
        bus.trc_pop = 1;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef PERF_TRACE_EN
            check_val("t4_order", 64'(bus.trc_rd_data), 64'(i));
`endif
            step();
        end
        bus.trc_pop = 0;
        check_val("t4_empty", 64'(bus.trc_empty), 64'd1);

        // 5: push&pop on full, then pop on empty
        bus.trc_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.trc_data = TRC_W'(100 + i);
            step();
        end
        bus.trc_data = TRC_W'(200); bus.trc_pop = 1; step();
        bus.trc_valid = 0; bus.trc_pop = 0;
`ifdef PERF_TRACE_EN
        check_val("t5_full",  64'(bus.trc_full),    64'd1);
        check_val("t5_drop",  64'(bus.trc_drop),    64'd2);
        check_val("t5_head",  64'(bus.trc_rd_data), 64'd101);
`endif
        bus.trc_pop = 1;
        for (int i = 0; i < DEPTH + 3; i++) step();
        bus.trc_pop = 0;
        check_val("t5_empty_pop", 64'(bus.trc_empty), 64'd1);

        // 6b: async reset mid-RUN takes effect before the next edge
        bus.clr = 1; bus.start = 1; step(); bus.clr = 0; bus.start = 0;
        bus.evt = 6'b101011; bus.trc_valid = 1; bus.trc_data = TRC_W'(7);
        bus.rd_sel = 3'd0;
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        check_val("t6_rst_state", 64'(bus.mon_state), 64'd0);
        check_val("t6_rst_rd",    64'(bus.rd_data),   64'd0);
        check_val("t6_rst_sat",   64'(bus.sat),       64'd0);
        check_val("t6_rst_empty", 64'(bus.trc_empty), 64'd1);
        check_val("t6_rst_drop",  64'(bus.trc_drop),  64'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.clr       = ($urandom_range(0, 79) == 0);
            bus.halt      = ($urandom_range(0, 49) == 0);
            bus.evt       = NUM_EVT'($urandom());
            bus.rd_sel    = 3'($urandom_range(0, 7));
            bus.trc_valid = $urandom_range(0, 1) == 1;
            bus.trc_data  = TRC_W'({$urandom(), $urandom()});
            bus.trc_pop   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
